ni_input_unit_param: RTL and testbench

- Parametrised next-generation PE network-interface input unit. Sits between router local output port and PE core.
- Decodes incoming flits by info field. Drives PE status/activation-RF config writes and controller strobes.
- Buffers BROADCAST/UV/FIN_BROADCAST activations and READ requests in internal FIFOs.
- Returns upstream credits through an accumulating counter, so simultaneous credit events are never lost.

---
 rtl/ni_input_unit_param_pkg.sv | 45 ++++
 rtl/ni_input_unit_param_sync_fifo.sv | 59 +++++
 rtl/ni_input_unit_param.sv | 182 ++++++++++++++++++
 tb/tb_ni_input_unit_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ni_input_unit_param_pkg.sv
// Shared definitions for the NI input unit: router info encodings, flit field
// positions and the credit-counter width helper.
package ni_input_unit_param_pkg;

  typedef enum logic [3:0] {
    INFO_CONFIG    = 4'h1,
    INFO_CALC      = 4'h2,
    INFO_FIN_COMP  = 4'h3,
    INFO_BROADCAST = 4'h4,
    INFO_UV        = 4'h5,
    INFO_FIN_BCAST = 4'h6,
    INFO_READ      = 4'h7
  } info_e;

  // addr bit that steers a CONFIG flit to the activation RF instead of status
  localparam int CFG_SEL_BIT = 7;

  typedef struct packed {
    logic stat_we;
    logic act_we;
    logic start_calc;
    logic comp_done;
    logic act_push;
    logic act_zero;
    logic rd_push;
    logic consume;
  } dec_t;

  function automatic int flit_data_lsb();
    return 0;
  endfunction

  function automatic int flit_addr_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int flit_info_lsb(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

  function automatic int credit_cnt_w(input int act_depth, input int rd_depth);
    return $clog2(act_depth + rd_depth + 3) + 1;
  endfunction

endpackage

// File: rtl/ni_input_unit_param_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty and a push-when-full pulse.
// DEPTH must be a power of two so the pointers wrap naturally.
module ni_input_unit_param_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_pop;
  logic             w_push;

  assign empty = (r_count == '0);
  assign full  = (r_count == (AW+1)'(DEPTH));
  assign dout  = r_mem[r_rptr];

  // a pop frees the slot, so a push on a full FIFO is still taken that cycle
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign ovf    = push & full & ~w_pop;

  // NOTE: storage has no reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ni_input_unit_param.sv
// PE network-interface input unit: flit decode, activation/read FIFOs and an
// accumulating upstream credit counter. Optional perf counters: NI_PERF_CNT_EN.
module ni_input_unit_param
  import ni_input_unit_param_pkg::*;
#(
  parameter int INFO_W    = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int PE_ADDR_W = 6,
  parameter int ACT_DEPTH = 8,
  parameter int RD_DEPTH  = 4,
  parameter int STAT_AW   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [INFO_W+ADDR_W+DATA_W-1:0] in_flit,
  input  logic [PE_ADDR_W-1:0]          out_act_no,
  output logic                          stat_we,
  output logic [STAT_AW-1:0]            stat_addr,
  output logic [DATA_W-1:0]             stat_data,
  output logic                          act_we,
  output logic [PE_ADDR_W-1:0]          act_waddr,
  output logic [DATA_W-1:0]             act_wdata,
  output logic                          start_calc,
  output logic                          comp_done,
  output logic                          act_valid,
  output logic [PE_ADDR_W+DATA_W-1:0]   act_data,
  input  logic                          act_pop,
  output logic                          rd_valid,
  output logic [PE_ADDR_W-1:0]          rd_addr,
  input  logic                          rd_ready,
  output logic                          upstream_credit,
  output logic                          ovf_err
`ifdef NI_PERF_CNT_EN
  ,
  output logic [31:0]                   perf_flits,
  output logic [31:0]                   perf_bcast
`endif
);

  localparam int ACT_W    = PE_ADDR_W + DATA_W;
  localparam int INFO_LSB = flit_info_lsb(ADDR_W, DATA_W);
  localparam int ADDR_LSB = flit_addr_lsb(DATA_W);
  localparam int DATA_LSB = flit_data_lsb();
  localparam int CNT_W    = credit_cnt_w(ACT_DEPTH, RD_DEPTH);

  logic [INFO_W-1:0] w_info;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  dec_t              w_dec;
  logic [ACT_W-1:0]  w_act_din;
  logic              w_act_empty, w_act_full, w_act_ovf, w_act_pop;
  logic              w_rd_empty, w_rd_full, w_rd_ovf, w_rd_pop;
  logic [1:0]        w_events;
  logic [CNT_W-1:0]  w_sum;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_credit;
  logic              r_ovf_err;
  logic              w_unused;

  assign w_info = in_flit[INFO_LSB +: INFO_W];
  assign w_addr = in_flit[ADDR_LSB +: ADDR_W];
  assign w_data = in_flit[DATA_LSB +: DATA_W];

  // NOTE: every decode field gets a default before the case so no latch is inferred.
  always_comb begin
    w_dec = '0;
    if (in_valid) begin
      case (w_info)
        INFO_W'(INFO_CONFIG): begin
          w_dec.consume = 1'b1;
          if (w_addr[CFG_SEL_BIT]) w_dec.act_we  = 1'b1;
          else                     w_dec.stat_we = 1'b1;
        end
        INFO_W'(INFO_CALC): begin
          w_dec.start_calc = 1'b1;
          w_dec.consume    = 1'b1;
        end
        INFO_W'(INFO_FIN_COMP): begin
          w_dec.comp_done = 1'b1;
          w_dec.consume   = 1'b1;
        end
        INFO_W'(INFO_BROADCAST): begin
          // a PE with no output activations has no use for the broadcast
          if (out_act_no != '0) w_dec.act_push = 1'b1;
          else                  w_dec.consume  = 1'b1;
        end
        INFO_W'(INFO_UV): w_dec.act_push = 1'b1;
        INFO_W'(INFO_FIN_BCAST): begin
          w_dec.act_push = 1'b1;
          w_dec.act_zero = 1'b1;
        end
        INFO_W'(INFO_READ): w_dec.rd_push = 1'b1;
        default: ;
      endcase
    end
  end

  assign stat_we    = w_dec.stat_we;
  assign stat_addr  = w_dec.stat_we ? w_addr[STAT_AW-1:0] : '0;
  assign stat_data  = w_dec.stat_we ? w_data : '0;
  assign act_we     = w_dec.act_we;
  assign act_waddr  = w_dec.act_we ? w_addr[PE_ADDR_W:1] : '0;
  assign act_wdata  = w_dec.act_we ? w_data : '0;
  assign start_calc = w_dec.start_calc;
  assign comp_done  = w_dec.comp_done;

  assign w_act_din = w_dec.act_zero ? '0 : {w_addr[PE_ADDR_W-1:0], w_data};
  assign w_act_pop = act_pop & ~w_act_empty;
  assign w_rd_pop  = rd_ready & ~w_rd_empty;

  ni_input_unit_param_sync_fifo #(.WIDTH(ACT_W), .DEPTH(ACT_DEPTH)) u_act_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_dec.act_push),
    .din   (w_act_din),
    .pop   (act_pop),
    .dout  (act_data),
    .full  (w_act_full),
    .empty (w_act_empty),
    .ovf   (w_act_ovf)
  );

  ni_input_unit_param_sync_fifo #(.WIDTH(PE_ADDR_W), .DEPTH(RD_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_dec.rd_push),
    .din   (w_addr[PE_ADDR_W-1:0]),
    .pop   (rd_ready),
    .dout  (rd_addr),
    .full  (w_rd_full),
    .empty (w_rd_empty),
    .ovf   (w_rd_ovf)
  );

  assign act_valid = ~w_act_empty;
  assign rd_valid  = ~w_rd_empty;

  // up to three credit events per cycle are banked and paid out one per cycle
  assign w_events = 2'(w_dec.consume) + 2'(w_act_pop) + 2'(w_rd_pop);
  assign w_sum    = r_cnt + CNT_W'(w_events);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_credit  <= 1'b0;
      r_ovf_err <= 1'b0;
    end else begin
      r_credit  <= (w_sum != '0);
      r_cnt     <= w_sum - CNT_W'(w_sum != '0);
      r_ovf_err <= r_ovf_err | w_act_ovf | w_rd_ovf;
    end
  end

  assign upstream_credit = r_credit;
  assign ovf_err         = r_ovf_err;

`ifdef NI_PERF_CNT_EN
  logic [31:0] r_perf_flits;
  logic [31:0] r_perf_bcast;
  logic        w_bcast_push;

  assign w_bcast_push = w_dec.act_push & ~w_dec.act_zero & ~w_act_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_flits <= '0;
      r_perf_bcast <= '0;
    end else begin
      if (in_valid && r_perf_flits != '1)     r_perf_flits <= r_perf_flits + 1'b1;
      if (w_bcast_push && r_perf_bcast != '1) r_perf_bcast <= r_perf_bcast + 1'b1;
    end
  end

  assign perf_flits = r_perf_flits;
  assign perf_bcast = r_perf_bcast;
`endif

  assign w_unused = ^{w_addr, w_act_full, w_rd_full};

endmodule

// File: tb/tb_ni_input_unit_param.sv
// Scoreboard bench for ni_input_unit_param: activation/read entries are queued
// as flits are driven and compared as they reach the FIFO heads.
module tb_ni_input_unit_param;

  localparam logic [3:0] I_CONFIG = 4'h1;
  localparam logic [3:0] I_CALC   = 4'h2;
  localparam logic [3:0] I_FINC   = 4'h3;
  localparam logic [3:0] I_BCAST  = 4'h4;
  localparam logic [3:0] I_UV     = 4'h5;
  localparam logic [3:0] I_FINB   = 4'h6;
  localparam logic [3:0] I_READ   = 4'h7;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [35:0] in_flit;
  logic [5:0]  out_act_no;
  logic        stat_we;
  logic [3:0]  stat_addr;
  logic [15:0] stat_data;
  logic        act_we;
  logic [5:0]  act_waddr;
  logic [15:0] act_wdata;
  logic        start_calc;
  logic        comp_done;
  logic        act_valid;
  logic [21:0] act_data;
  logic        act_pop;
  logic        rd_valid;
  logic [5:0]  rd_addr;
  logic        rd_ready;
  logic        upstream_credit;
  logic        ovf_err;

  int total = 0;
  int bad   = 0;

  logic [21:0] act_q[$];
  logic [5:0]  rd_q[$];
  int          m_cnt;
  logic        m_ovf;

  always #5 clk = ~clk;

  ni_input_unit_param dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_flit         (in_flit),
    .out_act_no      (out_act_no),
    .stat_we         (stat_we),
    .stat_addr       (stat_addr),
    .stat_data       (stat_data),
    .act_we          (act_we),
    .act_waddr       (act_waddr),
    .act_wdata       (act_wdata),
    .start_calc      (start_calc),
    .comp_done       (comp_done),
    .act_valid       (act_valid),
    .act_data        (act_data),
    .act_pop         (act_pop),
    .rd_valid        (rd_valid),
    .rd_addr         (rd_addr),
    .rd_ready        (rd_ready),
    .upstream_credit (upstream_credit),
    .ovf_err         (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, checks combinational decode and FIFO heads
  // before the edge, then credit/overflow state just after it.
  task automatic step(input logic v, input logic [3:0] info, input logic [15:0] addr,
                      input logic [15:0] data, input logic pop, input logic rdy);
    logic        imm, apush, rpush, apop, rpop, exp_credit;
    logic [21:0] aent;
    int          sum;
    in_valid = v;
    in_flit  = {info, addr, data};
    act_pop  = pop;
    rd_ready = rdy;
    #1;
    imm = 1'b0; apush = 1'b0; rpush = 1'b0;
    aent = {addr[5:0], data};
    if (v) begin
      case (info)
        I_CONFIG, I_CALC, I_FINC: imm = 1'b1;
        I_BCAST: if (out_act_no != 0) apush = 1'b1; else imm = 1'b1;
        I_UV:    apush = 1'b1;
        I_FINB:  begin apush = 1'b1; aent = '0; end
        I_READ:  rpush = 1'b1;
        default: ;
      endcase
    end
    check("stat_we", 32'(stat_we), 32'(v && info == I_CONFIG && !addr[7]));
    check("act_we", 32'(act_we), 32'(v && info == I_CONFIG && addr[7]));
    check("start_calc", 32'(start_calc), 32'(v && info == I_CALC));
    check("comp_done", 32'(comp_done), 32'(v && info == I_FINC));
    if (v && info == I_CONFIG && !addr[7]) begin
      check("stat_addr", 32'(stat_addr), 32'(addr[3:0]));
      check("stat_data", 32'(stat_data), 32'(data));
    end
    if (v && info == I_CONFIG && addr[7]) begin
      check("act_waddr", 32'(act_waddr), 32'(addr[6:1]));
      check("act_wdata", 32'(act_wdata), 32'(data));
    end
    check("act_valid", 32'(act_valid), 32'(act_q.size() != 0));
    if (act_q.size() != 0) check("act_data", 32'(act_data), 32'(act_q[0]));
    check("rd_valid", 32'(rd_valid), 32'(rd_q.size() != 0));
    if (rd_q.size() != 0) check("rd_addr", 32'(rd_addr), 32'(rd_q[0]));
    apop = pop && act_q.size() != 0;
    rpop = rdy && rd_q.size() != 0;
    if (apop) void'(act_q.pop_front());
    if (rpop) void'(rd_q.pop_front());
    if (apush) begin
      if (act_q.size() < 8) act_q.push_back(aent);
      else m_ovf = 1'b1;
    end
    if (rpush) begin
      if (rd_q.size() < 4) rd_q.push_back(addr[5:0]);
      else m_ovf = 1'b1;
    end
    @(posedge clk);
    sum = m_cnt + int'(imm) + int'(apop) + int'(rpop);
    exp_credit = (sum != 0);
    m_cnt = sum - int'(exp_credit);
    #1;
    check("upstream_credit", 32'(upstream_credit), 32'(exp_credit));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  // Asserts reset away from the clock edge and checks it clears state at once.
  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; act_pop = 1'b0; rd_ready = 1'b0;
    #1;
    check("rst act_valid", 32'(act_valid), 32'h0);
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst credit", 32'(upstream_credit), 32'h0);
    check("rst ovf_err", 32'(ovf_err), 32'h0);
    check("rst stat_we", 32'(stat_we), 32'h0);
    act_q.delete();
    rd_q.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_flit = '0;
    out_act_no = 6'd3;
    act_pop = 1'b0;
    rd_ready = 1'b0;
    m_cnt = 0;
    m_ovf = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    idle(1);

    // configuration writes, each returning one credit a cycle later
    step(1'b1, I_CONFIG, 16'h0003, 16'hBEEF, 1'b0, 1'b0);
    step(1'b1, I_CONFIG, 16'h0085, 16'h1234, 1'b0, 1'b0);
    idle(2);
    step(1'b1, I_FINC, 16'h0000, 16'h0000, 1'b0, 1'b0);
    idle(1);

    // broadcast dropped when the PE has no output activations, kept otherwise
    out_act_no = 6'd0;
    step(1'b1, I_BCAST, 16'h0005, 16'h0001, 1'b0, 1'b0);
    out_act_no = 6'd3;
    step(1'b1, I_BCAST, 16'h0005, 16'hFFFE, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 4'hF, 16'h0011, 16'h2222, 1'b0, 1'b0);
    idle(1);

    // three credit events in one cycle drain over three cycles
    step(1'b1, I_READ, 16'h0009, 16'h0000, 1'b0, 1'b0);
    step(1'b1, I_CALC, 16'h0000, 16'h0000, 1'b1, 1'b1);
    idle(4);

    // fill the activation FIFO, overflow it, then drain in order
    for (int i = 0; i < 8; i++) step(1'b1, I_UV, 16'(i + 1), 16'(16'hA000 + i), 1'b0, 1'b0);
    step(1'b1, I_UV, 16'h003F, 16'hDEAD, 1'b0, 1'b0);
    idle(1);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(3);
    do_reset();

    // push and pop together on a full FIFO keeps eight entries, no overflow
    for (int i = 0; i < 8; i++) step(1'b1, I_UV, 16'(i + 16), 16'(16'hB000 + i), 1'b0, 1'b0);
    step(1'b1, I_UV, 16'h0030, 16'hC0DE, 1'b1, 1'b0);
    step(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(3);

    // end marker follows the UV entries it trails
    step(1'b1, I_UV, 16'h0001, 16'h1111, 1'b0, 1'b0);
    step(1'b1, I_UV, 16'h0002, 16'h2222, 1'b0, 1'b0);
    step(1'b1, I_FINB, 16'h00FF, 16'hFFFF, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 1'b0);
    idle(3);

    // read FIFO overflow and in-order handshakes
    for (int i = 0; i < 5; i++) step(1'b1, I_READ, 16'(i + 32), 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 16'h0, 16'h0, 1'b0, 1'b1);
    idle(4);
    do_reset();

    // reset with queued activations and two banked credits
    for (int i = 0; i < 4; i++) step(1'b1, I_UV, 16'(i + 40), 16'(16'hD000 + i), 1'b0, 1'b0);
    step(1'b1, I_READ, 16'h0007, 16'h0000, 1'b0, 1'b0);
    idle(6);
    step(1'b1, I_CALC, 16'h0000, 16'h0000, 1'b1, 1'b1);
    do_reset();
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
